// File: rtl/product_chunk_serializer_pkg.sv
// Shared widths and sequencer encoding for the product chunk serializer.
// The width constants mirror outputIndex / multiplyIndex from definitions.h.
package product_chunk_serializer_pkg;

  localparam int OUTPUT_INDEX   = 15;
  localparam int MULTIPLY_INDEX = 31;

  localparam int OUT_W_DEF = OUTPUT_INDEX + 1;
  localparam int IN_W_DEF  = MULTIPLY_INDEX + 1;

  typedef enum logic {
    SEQ_LOW  = 1'b0,
    SEQ_HIGH = 1'b1
  } seq_state_t;

endpackage

// File: rtl/product_fifo.sv
// DEPTH x W word FIFO with wrapping pointers, occupancy count and synchronous flush.
// Push is refused when full even if a pop happens in the same cycle.
module product_fifo
  import product_chunk_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = IN_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_occ;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && (r_occ != FULL_OCC);
  assign w_pop  = i_pop && (r_occ != '0);

  // Entries are cleared on reset so the idle output shows a defined zero.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_rdata     = r_mem[r_rptr];
  assign o_occupancy = r_occ;

endmodule

// File: rtl/product_chunk_serializer.sv
// Buffers full-width products and emits them as two chunks, low half first.
// The LOW/HIGH sequencer state is exported directly as chunk_count.
module product_chunk_serializer
  import product_chunk_serializer_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF,
  parameter int IN_W  = IN_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     chunk_count,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam logic [$clog2(DEPTH):0] FULL_OCC = ($clog2(DEPTH)+1)'(DEPTH);

  if (IN_W != 2 * OUT_W) begin : g_bad_width
    $error("product_chunk_serializer: IN_W must equal 2*OUT_W");
  end

  seq_state_t                r_state;
  logic [IN_W-1:0]           w_head;
  logic [$clog2(DEPTH):0]    w_occ;
  logic                      w_push;
  logic                      w_xfer;
  logic                      w_pop;

  // Both ports: a transfer happens on a cycle where valid && ready; the
  // producer holds valid and data steady until then, and ready never
  // depends combinationally on the other port's ready.
  assign in_ready  = Rst && (w_occ != FULL_OCC) && !flush;
  assign out_valid = (w_occ != '0);
  assign w_push    = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;
  assign w_pop     = w_xfer && (r_state == SEQ_HIGH);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= SEQ_LOW;
    end else if (flush) begin
      r_state <= SEQ_LOW;
    end else if (w_xfer) begin
      r_state <= (r_state == SEQ_LOW) ? SEQ_HIGH : SEQ_LOW;
    end
  end

  product_fifo #(
    .DEPTH (DEPTH),
    .W     (IN_W)
  ) u_fifo (
    .Clk         (Clk),
    .Rst         (Rst),
    .flush       (flush),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (in_data),
    .o_rdata     (w_head),
    .o_occupancy (w_occ)
  );

  assign chunk_count = (r_state == SEQ_HIGH);
  assign out_last    = chunk_count;
  assign occupancy   = w_occ;
  assign out_data    = chunk_count ? w_head[IN_W-1:OUT_W] : w_head[OUT_W-1:0];

endmodule

// File: tb/tb_product_chunk_serializer.sv
// Bench for product_chunk_serializer: vector table, hand-written corner
// sequences and a randomized run against a chunk-queue reference model.
module tb_product_chunk_serializer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        chunk_count;
  logic [1:0]  occupancy;

  product_chunk_serializer #(.OUT_W(16), .IN_W(32), .DEPTH(2)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .chunk_count (chunk_count),
    .occupancy   (occupancy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;

  vec_t        vecs[5];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bp_exp[6];
  int          idx;
  logic        push_now;

  // random-run state
  int          sent;
  int          taken_chunks;
  int          occ_model;
  logic        prev_hold;
  logic [15:0] prev_data;
  logic        do_push;
  logic        do_pop;
  logic [15:0] exp_chunk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_single(input logic [31:0] w, input logic [15:0] lo, input logic [15:0] hi);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1'b1);
    check("single_lo", out_data, lo);
    check("single_last0", out_last, 1'b0);
    check("single_occ1", occupancy, 2'd1);
    tick();
    check("single_hi", out_data, hi);
    check("single_last1", out_last, 1'b1);
    tick();
    check("single_occ0", occupancy, 2'd0);
    check("single_idle", out_valid, 1'b0);
    check("single_cc0", chunk_count, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hBEEF_1234, 16'h1234, 16'hBEEF};
    vecs[1] = '{32'h0000_FFFF, 16'hFFFF, 16'h0000};
    vecs[2] = '{32'hFFFF_0000, 16'h0000, 16'hFFFF};
    vecs[3] = '{32'h1234_5678, 16'h5678, 16'h1234};
    vecs[4] = '{32'h8001_7FFE, 16'h7FFE, 16'h8001};
    bp_exp[0] = 16'h5555; bp_exp[1] = 16'hAAAA; bp_exp[2] = 16'h3333;
    bp_exp[3] = 16'hCCCC; bp_exp[4] = 16'h2222; bp_exp[5] = 16'h1111;

    Rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occ", occupancy, 2'd0);
    check("rst_cc", chunk_count, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, 16'h0000);
    tick();
    Rst = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    tick();

    for (int i = 0; i < 5; i++) run_single(vecs[i].word, vecs[i].exp_lo, vecs[i].exp_hi);

    // back-pressure: three words with consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_5555;
    tick();
    check("bp_occ1", occupancy, 2'd1);
    check("bp_ready1", in_ready, 1'b1);
    in_data = 32'hCCCC_3333;
    tick();
    check("bp_ready_full", in_ready, 1'b0);
    in_data = 32'h1111_2222;
    tick();
    check("bp_occ_held", occupancy, 2'd2);
    check("bp_ready_held", in_ready, 1'b0);
    check("bp_head_stable", out_data, 16'h5555);
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      if (out_valid) begin
        check("bp_chunk", out_data, bp_exp[idx]);
        idx++;
      end
      push_now = in_valid && in_ready;
      tick();
      if (push_now) in_valid = 1'b0;
    end
    check("bp_count", idx, 6);
    out_ready = 1'b0;
    check("bp_drained", occupancy, 2'd0);

    // simultaneous push and pop at occupancy 1 in HIGH
    in_valid = 1'b1;
    in_data  = 32'h0102_0304;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 32'h0506_0708;
    check("pp_cc_pre", chunk_count, 1'b1);
    check("pp_occ_pre", occupancy, 2'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pp_occ", occupancy, 2'd1);
    check("pp_cc", chunk_count, 1'b0);
    check("pp_head", out_data, 16'h0708);
    out_ready = 1'b1;
    tick();
    check("pp_head_hi", out_data, 16'h0506);
    tick();
    out_ready = 1'b0;
    check("pp_drained", occupancy, 2'd0);

    // flush with HIGH selected, two words stored and a word offered
    in_valid = 1'b1;
    in_data  = 32'h1111_AAAA;
    tick();
    in_data = 32'h2222_BBBB;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fl_cc_pre", chunk_count, 1'b1);
    check("fl_occ_pre", occupancy, 2'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h3333_CCCC;
    #1;
    check("fl_in_ready", in_ready, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_occ", occupancy, 2'd0);
    check("fl_valid", out_valid, 1'b0);
    check("fl_cc", chunk_count, 1'b0);
    tick();
    check("fl_no_late_push", occupancy, 2'd0);

    // asynchronous reset while full with HIGH selected
    in_valid = 1'b1;
    in_data  = 32'h4444_DDDD;
    tick();
    in_data = 32'h5555_EEEE;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ar_cc_pre", chunk_count, 1'b1);
    check("ar_occ_pre", occupancy, 2'd2);
    #3;
    Rst = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_occ", occupancy, 2'd0);
    check("ar_cc", chunk_count, 1'b0);
    check("ar_in_ready", in_ready, 1'b0);
    #2;
    Rst = 1'b1;
    tick();
    run_single(32'hCAFE_F00D, 16'hF00D, 16'hCAFE);

    // randomized traffic against a chunk-queue model
    sent = 0; taken_chunks = 0; occ_model = 0; prev_hold = 1'b0; prev_data = '0;
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 3000 && (sent < 100 || exp_q.size() != 0); c++) begin
      if (prev_hold) check("rnd_stable", out_data, prev_data);
      check("rnd_occ", occupancy, occ_model[1:0]);
      do_push = in_valid && in_ready;
      do_pop  = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_chunk", out_valid, 1'b0);
        end else begin
          exp_chunk = exp_q.pop_front();
          check("rnd_data", out_data, exp_chunk);
          check("rnd_last", out_last, taken_chunks % 2);
        end
        do_pop = (taken_chunks % 2) == 1;
        taken_chunks++;
      end
      if (do_push) begin
        exp_q.push_back(in_data[15:0]);
        exp_q.push_back(in_data[31:16]);
        sent++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      tick();
      occ_model = occ_model + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
      if (do_push || !in_valid) begin
        in_valid = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    check("rnd_words_sent", sent, 100);
    check("rnd_chunks_taken", taken_chunks, 200);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/product_chunk_serializer.md
# product_chunk_serializer

Downstream companion to the product split stage: accepts full-width multiply results (two output chunks wide) on a valid/ready interface and buffers them in a small FIFO. It drives them out one output-width chunk per transfer, low half first, then high half, on a second valid/ready interface. It owns the chunk-select sequencing, which it exports as `chunk_count`, so the output path no longer needs a free-running select.

## Interface
- `OUT_W`, 16: chunk width; equals `outputIndex`+1 from `definitions.h`.
- `IN_W`, 2*OUT_W: product width; equals `multiplyIndex`+1. Any other value is illegal.
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `Clk`  in  1  sole clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-low; asserted at 0.
- `flush`  in  1  synchronous clear of FIFO and sequencing.
- `in_valid`  in  1  product word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  IN_W  product word.
- `out_valid`  out  1  chunk present.
- `out_ready`  in  1  consumer takes the chunk.
- `out_data`  out  OUT_W  current chunk.
- `out_last`  out  1  current chunk is the high half.
- `chunk_count`  out  1  0 = low half selected, 1 = high half selected.
- `occupancy`  out  $clog2(DEPTH)+1  words held in the FIFO.

## Operation
- Storage is a DEPTH-entry FIFO with read and write pointers and `occupancy`.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready && chunk_count==1`.
- `in_ready = (occupancy != DEPTH) && !flush`. There is no combinational path from `out_ready` to `in_ready`. When the FIFO is full, no push occurs even if a pop happens in the same cycle.
- `out_valid = (occupancy != 0)`. `out_data` is a combinational mux from the head entry: bits [OUT_W-1:0] when `chunk_count`=0, bits [IN_W-1:OUT_W] when `chunk_count`=1. `out_last = chunk_count`.
- Sequencer has two states, LOW (`chunk_count`=0) and HIGH (`chunk_count`=1):
  - LOW goes to HIGH on an output transfer.
  - HIGH goes to LOW on an output transfer, and the head word is popped.
  - With no transfer, the state holds. The state never advances while `out_valid`=0.
- Push and pop in the same cycle leave `occupancy` unchanged, and both pointers advance.
- Pointers wrap modulo DEPTH.
- `flush` takes priority over push and pop in the same cycle. It sets pointers and `occupancy` to 0 and the state to LOW, and any in-progress word is discarded.
- Asserting `Rst` mid-operation discards all content immediately, without waiting for a clock edge.
- Once `out_valid`=1, `out_data` must stay stable until the transfer completes.

## Timing
- Reset values:
  - `in_ready`=1 after release (0 while `Rst` is asserted).
  - `out_valid`=0, `out_last`=0, `chunk_count`=0, `occupancy`=0.
  - `out_data` = low half of entry 0, which is cleared to 0.
- Latency: a word pushed at edge N gives `out_valid`=1 in the cycle after edge N, with the low chunk on `out_data`.
- With `out_ready` held at 1, one chunk transfers per cycle. The sustained input rate is therefore one word per two cycles.
- `occupancy` updates on the edge of the push or pop.

## Structure
- `OUT_W` and `IN_W` come from the `outputIndex` and `multiplyIndex` constants in `definitions.h`. No new constants are added locally.
- One sub-module, `product_fifo`: parameterised DEPTH×IN_W storage with pointers, `occupancy`, `flush`, and asynchronous active-low reset.
- The top level holds the LOW/HIGH sequencer and the output mux.

## Test plan
- Reset, then push 0xBEEF_1234 with `out_ready`=1:
  - next cycle `out_data`=0x1234, `out_last`=0;
  - following cycle `out_data`=0xBEEF, `out_last`=1;
  - `occupancy` then returns to 0.
- Back-pressure:
  - Push 0xAAAA_5555, 0xCCCC_3333, 0x1111_2222 back-to-back with `out_ready`=0. `in_ready` drops after the second push and the third word is held.
  - Release `out_ready`. The chunk order is 5555, AAAA, 3333, CCCC, then 2222, 1111.
- Stability: with `out_ready` toggling 0/1 randomly, `out_data` stays stable while `out_valid`=1 and `out_ready`=0. All 100 random words are reassembled correctly.
- Simultaneous push and pop at `occupancy`=1, with `chunk_count`=1 and `out_ready`=1: `occupancy` stays 1, the new word becomes the head, and `chunk_count` returns to 0.
- Flush: assert `flush` with `chunk_count`=1, two words stored, and `in_valid`=1. Next cycle `occupancy`=0, `out_valid`=0, `chunk_count`=0, and the input word is not accepted.
- Asynchronous reset: assert `Rst` mid-cycle while full. `out_valid`, `occupancy` and `chunk_count` go to 0 before the next edge, and operation resumes normally after release.
